// File: rtl/d_ff_shift_reg.sv
// WIDTH-bit register bank with enable, synchronous reset, and eight modes:
// hold, load, shift, rotate, arithmetic shift and clear, with q/qb, so, changed.
module d_ff_shift_reg #(
  parameter int              WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d_in,
  input  logic             si_left,
  input  logic             si_right,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             so,
  output logic             changed
);

  localparam int N = WIDTH - 1;

  typedef enum logic [2:0] {
    M_HOLD = 3'b000,
    M_LOAD = 3'b001,
    M_SHL  = 3'b010,
    M_SHR  = 3'b011,
    M_ROL  = 3'b100,
    M_ROR  = 3'b101,
    M_ASR  = 3'b110,
    M_CLR  = 3'b111
  } mode_e;

  logic [WIDTH-1:0] q_next;
  logic             so_next;

  always_comb begin
    q_next  = q;
    so_next = so;
    unique case (mode_e'(mode))
      M_HOLD: ;
      M_LOAD: q_next = d_in;
      M_SHL: begin
        q_next  = {q[N-1:0], si_left};
        so_next = q[N];
      end
      M_SHR: begin
        q_next  = {si_right, q[N:1]};
        so_next = q[0];
      end
      M_ROL: begin
        q_next  = {q[N-1:0], q[N]};
        so_next = q[N];
      end
      M_ROR: begin
        q_next  = {q[0], q[N:1]};
        so_next = q[0];
      end
      // sign bit replicated, si_right not used
      M_ASR: begin
        q_next  = {q[N], q[N:1]};
        so_next = q[0];
      end
      M_CLR: begin
        q_next  = '0;
        so_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q       <= RESET_VALUE;
      so      <= 1'b0;
      changed <= 1'b0;
    end else if (!en) begin
      changed <= 1'b0;
    end else begin
      q       <= q_next;
      so      <= so_next;
      changed <= (q_next != q);
    end
  end

  assign qb = ~q;

endmodule

// File: tb/tb_d_ff_shift_reg.sv
// Directed scoreboard bench for d_ff_shift_reg at WIDTH=8 (RV A5)
// and WIDTH=2 (RV 01).
module tb_d_ff_shift_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, si_left, si_right;
  logic [2:0] mode;
  logic [7:0] d_in, q, qb;
  logic       so, changed;

  logic       r2, e2, sl2, sr2;
  logic [2:0] m2;
  logic [1:0] d2, q2, qb2;
  logic       so2, ch2;

  d_ff_shift_reg #(.WIDTH(8), .RESET_VALUE(8'hA5)) u8 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d_in(d_in),
    .si_left(si_left), .si_right(si_right),
    .q(q), .qb(qb), .so(so), .changed(changed)
  );

  d_ff_shift_reg #(.WIDTH(2), .RESET_VALUE(2'b01)) u2 (
    .clk(clk), .rst(r2), .en(e2), .mode(m2), .d_in(d2),
    .si_left(sl2), .si_right(sr2),
    .q(q2), .qb(qb2), .so(so2), .changed(ch2)
  );

  typedef struct {
    string      tag;
    logic [7:0] q;
    logic       so;
    logic       ch;
    bit         w2;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  always @(posedge clk) begin
    assert (!(en === 1'b1 && $isunknown(mode)) &&
            !(e2 === 1'b1 && $isunknown(m2)))
    else begin
      bad++;
      $error("FAIL xmode en=%b mode=%b e2=%b m2=%b", en, mode, e2, m2);
    end
  end

  task automatic chk(string tag, string f, logic [7:0] obs, logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, f, obs, exp);
    end
  endtask

  task automatic check();
    exp_t x;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard observed=empty expected=entry");
    end else begin
      x = sb.pop_front();
      if (x.w2) begin
        chk(x.tag, "q", {6'b0, q2}, x.q);
        chk(x.tag, "qb", {6'b0, qb2}, {6'b0, ~x.q[1:0]});
        chk(x.tag, "so", {7'b0, so2}, {7'b0, x.so});
        chk(x.tag, "changed", {7'b0, ch2}, {7'b0, x.ch});
      end else begin
        chk(x.tag, "q", q, x.q);
        chk(x.tag, "qb", qb, ~x.q);
        chk(x.tag, "so", {7'b0, so}, {7'b0, x.so});
        chk(x.tag, "changed", {7'b0, changed}, {7'b0, x.ch});
      end
    end
  endtask

  task automatic push(string tag, logic [7:0] eq, logic eso, logic ech, bit w2);
    exp_t x;
    x.tag = tag;
    x.q   = eq;
    x.so  = eso;
    x.ch  = ech;
    x.w2  = w2;
    sb.push_back(x);
  endtask

  task automatic step(string tag, logic r, logic e, logic [2:0] m,
                      logic [7:0] d, logic sl, logic sr,
                      logic [7:0] eq, logic eso, logic ech);
    rst = r; en = e; mode = m; d_in = d; si_left = sl; si_right = sr;
    push(tag, eq, eso, ech, 1'b0);
    @(posedge clk);
    #1;
    check();
  endtask

  task automatic step2(string tag, logic r, logic e, logic [2:0] m,
                       logic [1:0] d, logic sl, logic sr,
                       logic [1:0] eq, logic eso, logic ech);
    r2 = r; e2 = e; m2 = m; d2 = d; sl2 = sl; sr2 = sr;
    push(tag, {6'b0, eq}, eso, ech, 1'b1);
    @(posedge clk);
    #1;
    check();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 3'b000; d_in = 8'h00;
    si_left = 1'b0; si_right = 1'b0;
    r2 = 1'b1; e2 = 1'b0; m2 = 3'b000; d2 = 2'b00;
    sl2 = 1'b0; sr2 = 1'b0;

    step("rst0", 1, 0, 3'b000, 8'h00, 0, 0, 8'hA5, 0, 0);
    step("rst1", 1, 0, 3'b000, 8'h00, 0, 0, 8'hA5, 0, 0);
    step("hold0", 0, 0, 3'b001, 8'hFF, 0, 0, 8'hA5, 0, 0);
    step("hold1", 0, 0, 3'b010, 8'hFF, 1, 0, 8'hA5, 0, 0);
    step("hold2", 0, 0, 3'b111, 8'hFF, 0, 0, 8'hA5, 0, 0);

    step("load", 0, 1, 3'b001, 8'h3C, 0, 0, 8'h3C, 0, 1);
    step("load_same", 0, 1, 3'b001, 8'h3C, 0, 0, 8'h3C, 0, 0);
    step("en0_clr", 0, 0, 3'b111, 8'h00, 0, 0, 8'h3C, 0, 0);

    step("clr", 0, 1, 3'b111, 8'h00, 0, 0, 8'h00, 0, 1);
    step("shl1", 0, 1, 3'b010, 8'h00, 1, 0, 8'h01, 0, 1);
    step("shl2", 0, 1, 3'b010, 8'h00, 0, 0, 8'h02, 0, 1);
    step("shl3", 0, 1, 3'b010, 8'h00, 1, 0, 8'h05, 0, 1);
    step("shl4", 0, 1, 3'b010, 8'h00, 1, 0, 8'h0B, 0, 1);

    step("load81", 0, 1, 3'b001, 8'h81, 0, 0, 8'h81, 0, 1);
    step("rol", 0, 1, 3'b100, 8'h00, 0, 0, 8'h03, 1, 1);
    step("ror", 0, 1, 3'b101, 8'h00, 0, 0, 8'h81, 1, 1);
    step("asr1", 0, 1, 3'b110, 8'h00, 0, 0, 8'hC0, 1, 1);
    step("asr2", 0, 1, 3'b110, 8'h00, 0, 0, 8'hE0, 0, 1);

    step("loadFF", 0, 1, 3'b001, 8'hFF, 0, 0, 8'hFF, 0, 1);
    step("rolFF", 0, 1, 3'b100, 8'h00, 0, 0, 8'hFF, 1, 0);
    step("clr2", 0, 1, 3'b111, 8'h00, 0, 0, 8'h00, 0, 1);

    step("shr1", 0, 1, 3'b011, 8'h00, 0, 1, 8'h80, 0, 1);
    step("shr2", 0, 1, 3'b011, 8'h00, 0, 1, 8'hC0, 0, 1);
    step("shr3", 0, 1, 3'b011, 8'h00, 0, 1, 8'hE0, 0, 1);
    step("rst_mid", 1, 1, 3'b011, 8'h00, 0, 1, 8'hA5, 0, 0);
    step("rst_off", 0, 0, 3'b011, 8'h00, 0, 1, 8'hA5, 0, 0);
    step("rst_rv", 1, 1, 3'b001, 8'h00, 0, 0, 8'hA5, 0, 0);
    step("hold_en", 0, 1, 3'b000, 8'h12, 1, 1, 8'hA5, 0, 0);
    step("asr_sr0", 0, 1, 3'b110, 8'h00, 0, 0, 8'hD2, 1, 1);

    step2("w2_rst", 1, 0, 3'b000, 2'b00, 0, 0, 2'b01, 0, 0);
    step2("w2_shr", 0, 1, 3'b011, 2'b00, 0, 0, 2'b00, 1, 1);
    step2("w2_rol0", 0, 1, 3'b100, 2'b00, 0, 0, 2'b00, 0, 0);
    step2("w2_load", 0, 1, 3'b001, 2'b10, 0, 0, 2'b10, 0, 1);
    step2("w2_asr", 0, 1, 3'b110, 2'b00, 0, 1, 2'b11, 0, 1);
    step2("w2_shl", 0, 1, 3'b010, 2'b00, 0, 0, 2'b10, 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
